lfsr_seq_gen: RTL and testbench

Parametrised pseudo-random sequence generator. It is the next generation of the switch-programmed 8-bit LFSR block.
- Any WIDTH; the tap set is a full bit-mask rather than two tap indices.
- Selectable Fibonacci or Galois structure.
- Explicit seed; runs a programmed number of steps.
- Handshake: start/busy/done, plus abort and a lock-up error flag.
- Sits behind the switch/user-I/O wrapper as a start-and-wait compute unit.

---
 rtl/lfsr_seq_gen.sv | 110 +++++++++++
 tb/tb_lfsr_seq_gen.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_seq_gen.sv
// Parametrised LFSR sequence generator (Fibonacci or Galois) that runs a
// programmed number of shifts from an explicit seed and then pulses done.
module lfsr_seq_gen #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             mode,
  input  logic [WIDTH-1:0] tap_mask,
  input  logic [WIDTH-1:0] seed,
  input  logic [CNT_W-1:0] steps,
  output logic [WIDTH-1:0] num,
  output logic             busy,
  output logic             done,
  output logic             err_zero
);

  // Handshake: start is a level sampled only in IDLE/DONE; while busy is high
  // start is ignored and abort (sampled only in LOAD/RUN) returns to IDLE with
  // no done pulse. done is high for exactly the DONE state cycle.
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state, state_next;
  logic             mode_q;
  logic [WIDTH-1:0] tap_q, seed_q;
  logic [CNT_W-1:0] steps_q, cnt;
  logic             zero_cfg, last_step;
  logic [WIDTH-1:0] fib_next, gal_next, shift_next;

  assign zero_cfg   = (seed_q == '0) || (tap_q == '0);
  assign last_step  = ((cnt + CNT_ONE) == steps_q);
  assign fib_next   = {num[WIDTH-2:0], ^(num & tap_q)};
  assign gal_next   = {num[WIDTH-2:0], 1'b0} ^ (num[WIDTH-1] ? tap_q : '0);
  assign shift_next = mode_q ? gal_next : fib_next;

  assign busy = (state == LOAD) || (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = LOAD;
      LOAD: begin
        if (abort)                             state_next = IDLE;
        else if (zero_cfg || steps_q == '0)    state_next = DONE;
        else                                   state_next = RUN;
      end
      RUN: begin
        if (abort)          state_next = IDLE;
        else if (last_step) state_next = DONE;
      end
      DONE: state_next = start ? LOAD : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num      <= '0;
      cnt      <= '0;
      err_zero <= 1'b0;
      mode_q   <= 1'b0;
      tap_q    <= '0;
      seed_q   <= '0;
      steps_q  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            mode_q   <= mode;
            tap_q    <= tap_mask;
            seed_q   <= seed;
            steps_q  <= steps;
            err_zero <= 1'b0;
          end
        end
        LOAD: begin
          // A valid seed is loaded even when aborting so num shows the seed.
          if (zero_cfg) begin
            if (!abort) begin
              num      <= '0;
              err_zero <= 1'b1;
            end
          end else begin
            num <= seed_q;
            cnt <= '0;
          end
        end
        RUN: begin
          if (!abort) begin
            num <= shift_next;
            cnt <= cnt + CNT_ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_seq_gen.sv
// Self-checking bench for lfsr_seq_gen: an 8-bit and a 4-bit instance share
// stimulus; expected sequences come from an arithmetic reference model.
module tb_lfsr_seq_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] tap_mask = '0;
  logic [7:0] seed = '0;
  logic [7:0] steps = '0;

  logic [7:0] num8;
  logic [3:0] num4;
  logic       busy8, done8, err8, busy4, done4, err4;

  logic       sel4 = 1'b0;
  logic [7:0] o_num;
  logic       o_busy, o_done, o_err;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  lfsr_seq_gen #(.WIDTH(8), .CNT_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
    .tap_mask(tap_mask), .seed(seed), .steps(steps),
    .num(num8), .busy(busy8), .done(done8), .err_zero(err8)
  );

  lfsr_seq_gen #(.WIDTH(4), .CNT_W(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
    .tap_mask(tap_mask[3:0]), .seed(seed[3:0]), .steps(steps),
    .num(num4), .busy(busy4), .done(done4), .err_zero(err4)
  );

  always_comb begin
    o_num  = sel4 ? {4'b0, num4} : num8;
    o_busy = sel4 ? busy4 : busy8;
    o_done = sel4 ? done4 : done8;
    o_err  = sel4 ? err4  : err8;
  end

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: one shift computed with plain arithmetic on integers.
  function automatic int model_step(int w, bit m, int mask, int v);
    int top;
    int nv;
    top = 1 << w;
    if (!m) begin
      nv = (v * 2 + ($countones(v & mask) % 2)) % top;
    end else begin
      nv = (v * 2) % top;
      if (v >= top / 2) nv = nv ^ mask;
    end
    return nv;
  endfunction

  // Drives one run and checks every cycle. exp_final < 0 skips the
  // constant final-value check; chk_period checks distinct values in RUN.
  task automatic run_seq(input int w, input bit m, input int mask, input int sd,
                         input int st, input int exp_final, input bit chk_period);
    int v;
    int last;
    int distinct;
    bit zero;
    bit [255:0] seen;
    logic [31:0] e;
    seen = '0;
    distinct = 0;
    sel4 = (w == 4);
    zero = ((sd % (1 << w)) == 0) || ((mask % (1 << w)) == 0);
    exp_q.delete();
    if (!zero) begin
      v = sd % (1 << w);
      exp_q.push_back(v);
      for (int k = 0; k < st; k++) begin
        v = model_step(w, m, mask % (1 << w), v);
        exp_q.push_back(v);
      end
    end
    @(negedge clk);
    mode = m; tap_mask = mask[7:0]; seed = sd[7:0]; steps = st[7:0]; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    mode = $urandom_range(0, 1); tap_mask = $urandom; seed = $urandom;
    steps = $urandom;
    check("load_busy", o_busy, 1);
    check("load_done", o_done, 0);
    check("load_err", o_err, 0);
    if (zero) begin
      @(posedge clk); #1;
      check("err_done", o_done, 1);
      check("err_busy", o_busy, 0);
      check("err_num", o_num, 0);
      check("err_flag", o_err, 1);
      last = 0;
    end else begin
      last = 0;
      for (int c = 1; c <= st + 1; c++) begin
        @(posedge clk); #1;
        e = exp_q.pop_front();
        last = e;
        check("run_num", o_num, e);
        check("run_busy", o_busy, (c <= st) ? 1 : 0);
        check("run_done", o_done, (c == st + 1) ? 1 : 0);
        if (c <= st && !seen[o_num]) begin
          seen[o_num] = 1'b1;
          distinct++;
        end
      end
      check("run_err", o_err, 0);
      if (exp_final >= 0) check("final_const", o_num, exp_final);
      if (chk_period) check("period_distinct", distinct, st);
    end
    @(posedge clk); #1;
    check("idle_done", o_done, 0);
    check("idle_busy", o_busy, 0);
    check("hold_num", o_num, last);
  endtask

  task automatic abort_test();
    int v;
    int sd;
    int m;
    int mask;
    sel4 = 1'b0;
    sd = $urandom_range(1, 255);
    mask = $urandom_range(1, 255);
    m = $urandom_range(0, 1);
    @(negedge clk);
    mode = m[0]; tap_mask = mask[7:0]; seed = sd[7:0]; steps = 8'd10; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;                       // RUN, num = seed
    check("abort_seed", o_num, sd);
    @(negedge clk);
    seed = 8'h00; start = 1'b1;               // must be ignored while busy
    @(posedge clk); #1 start = 1'b0;
    v = model_step(8, m[0], mask, sd);
    check("start_ignored", o_num, v);
    @(posedge clk); #1;
    v = model_step(8, m[0], mask, v);
    @(posedge clk); #1;
    v = model_step(8, m[0], mask, v);
    check("abort_step3", o_num, v);
    @(negedge clk) begin abort = 1'b1; start = 1'b1; end
    @(posedge clk); #1 begin abort = 1'b0; start = 1'b0; end
    check("abort_busy", o_busy, 0);
    check("abort_done", o_done, 0);
    check("abort_num", o_num, v);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("abort_no_done", o_done, 0);
      check("abort_hold", o_num, v);
    end
  endtask

  task automatic reset_midrun_test();
    sel4 = 1'b0;
    @(negedge clk);
    mode = 1'b0; tap_mask = 8'hB8; seed = 8'h01; steps = 8'd20; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rst_num", o_num, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_release", o_busy, 0);
  endtask

  initial begin
    #12;
    check("reset_num8", num8, 0);
    check("reset_num4", num4, 0);
    check("reset_busy", busy8, 0);
    check("reset_done", done8, 0);
    check("reset_err", err8, 0);
    @(negedge clk) rst_n = 1'b1;

    run_seq(8, 1'b0, 8'hB8, 8'h01, 4, 8'h11, 1'b0);
    run_seq(8, 1'b1, 8'h1D, 8'h80, 2, 8'h3A, 1'b0);
    run_seq(4, 1'b0, 4'h9, 4'h1, 1, 4'h3, 1'b0);
    run_seq(4, 1'b0, 4'h9, 4'h1, 15, 4'h1, 1'b1);
    run_seq(8, 1'b0, 8'hB8, 8'h5A, 0, 8'h5A, 1'b0);
    run_seq(8, 1'b0, 8'hB8, 8'h00, 5, -1, 1'b0);
    run_seq(8, 1'b1, 8'h00, 8'h33, 5, -1, 1'b0);
    run_seq(8, 1'b1, 8'h1D, 8'h33, 3, -1, 1'b0);
    abort_test();
    for (int i = 0; i < 25; i++) begin
      if (i % 3 == 0)
        run_seq(4, $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 15),
                $urandom_range(0, 20), -1, 1'b0);
      else
        run_seq(8, $urandom_range(0, 1), $urandom_range(1, 255), $urandom_range(0, 255),
                $urandom_range(0, 30), -1, 1'b0);
    end
    run_seq(8, 1'b0, 8'hB8, 8'h01, 255, -1, 1'b0);
    reset_midrun_test();
    run_seq(8, 1'b1, 8'h1D, 8'h80, 2, 8'h3A, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
